// File: rtl/flood_mark_pkg.sv
// Shared constants, state encoding and neighbour offsets for flood_mark.
// Defining FLOOD_DIAG_EN selects the 8-cell neighbourhood instead of 4.
package flood_mark_pkg;

    localparam int GRID_N      = 8;
    localparam int CELL_IDX_W  = 6;
    localparam int EMPTY_COLOR = 0;

    typedef enum logic [2:0] {
        IDLE,
        SEED_RD,
        SEED_CHK,
        POP,
        NB_RD,
        NB_CHK,
        FIN
    } state_t;

    // Offsets are visited in table order; "up" is the row with the smaller y.
`ifdef FLOOD_DIAG_EN
    localparam int NB_COUNT = 8;
    localparam logic signed [4:0] NB_DX [NB_COUNT] =
        '{-5'sd1, 5'sd1, 5'sd0, 5'sd0, -5'sd1, 5'sd1, -5'sd1, 5'sd1};
    localparam logic signed [4:0] NB_DY [NB_COUNT] =
        '{5'sd0, 5'sd0, -5'sd1, 5'sd1, -5'sd1, -5'sd1, 5'sd1, 5'sd1};
`else
    localparam int NB_COUNT = 4;
    localparam logic signed [4:0] NB_DX [NB_COUNT] = '{-5'sd1, 5'sd1, 5'sd0, 5'sd0};
    localparam logic signed [4:0] NB_DY [NB_COUNT] = '{5'sd0, 5'sd0, -5'sd1, 5'sd1};
`endif

    localparam int NB_KW = $clog2(NB_COUNT);

    function automatic logic [CELL_IDX_W-1:0] cell_idx(input logic [2:0] cx,
                                                       input logic [2:0] cy);
        return {cy, cx};
    endfunction

endpackage

// File: rtl/flood_mark_queue.sv
// cell_queue: 64-entry FIFO of cell indices for the breadth-first fill.
// clear empties the queue in one cycle and wins over a simultaneous push.
module cell_queue
    import flood_mark_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [CELL_IDX_W-1:0] push_data,
    input  logic                  pop,
    output logic [CELL_IDX_W-1:0] pop_data,
    output logic                  empty
);

    localparam int DEPTH = GRID_N * GRID_N;

    logic [CELL_IDX_W-1:0] mem [DEPTH];
    logic [CELL_IDX_W-1:0] wr_ptr;
    logic [CELL_IDX_W-1:0] rd_ptr;
    logic [CELL_IDX_W:0]   fill;
    logic                  do_pop;

    assign empty    = (fill == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill <= fill + (CELL_IDX_W+1)'(push) - (CELL_IDX_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/flood_mark.sv
// Breadth-first flood fill over the 8x8 board, producing a group mask and size.
// Build option: define FLOOD_DIAG_EN to include diagonal neighbours.
module flood_mark
    import flood_mark_pkg::*;
#(
    parameter int COLOR_W   = 3,
    parameter int MIN_GROUP = 2
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         x,
    input  logic [3:0]         y,
    output logic               rd_en,
    output logic [3:0]         rd_x,
    output logic [3:0]         rd_y,
    input  logic [COLOR_W-1:0] rd_color,
    output logic               busy,
    output logic               done,
    output logic               ok,
    output logic [6:0]         count,
    output logic [63:0]        mark
);

    state_t                state;
    state_t                next_state;
    logic [2:0]            cur_x;
    logic [2:0]            cur_y;
    logic [NB_KW-1:0]      k;
    logic [COLOR_W-1:0]    ref_color;

    logic                  q_clear;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_empty;
    logic [CELL_IDX_W-1:0] q_push_data;
    logic [CELL_IDX_W-1:0] q_pop_data;

    logic signed [4:0]     nx;
    logic signed [4:0]     ny;
    logic [CELL_IDX_W-1:0] nb_idx;
    logic                  nb_on_board;
    logic                  nb_skip;
    logic                  nb_last;
    logic                  color_match;
    logic                  seed_bad;
    logic                  seed_empty;

    cell_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (q_clear),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_pop_data),
        .empty     (q_empty)
    );

    // mark doubles as the visited set: a cell is marked when it is enqueued.
    always_comb begin
        nx          = $signed({2'b00, cur_x}) + NB_DX[k];
        ny          = $signed({2'b00, cur_y}) + NB_DY[k];
        nb_on_board = (nx[4:3] == 2'b00) && (ny[4:3] == 2'b00);
        nb_idx      = cell_idx(nx[2:0], ny[2:0]);
        nb_skip     = !nb_on_board || mark[nb_idx];
        nb_last     = (k == NB_KW'(NB_COUNT - 1));
        color_match = (rd_color == ref_color);
        seed_bad    = (x > 4'd7) || (y > 4'd7);
        seed_empty  = (rd_color == COLOR_W'(EMPTY_COLOR));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        rd_en       = 1'b0;
        rd_x        = 4'd0;
        rd_y        = 4'd0;
        q_clear     = 1'b0;
        q_push      = 1'b0;
        q_pop       = 1'b0;
        q_push_data = nb_idx;
        done        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    q_clear    = 1'b1;
                    next_state = seed_bad ? FIN : SEED_RD;
                end
            end
            SEED_RD: begin
                rd_en      = 1'b1;
                rd_x       = {1'b0, cur_x};
                rd_y       = {1'b0, cur_y};
                next_state = SEED_CHK;
            end
            SEED_CHK: begin
                if (seed_empty) begin
                    next_state = FIN;
                end else begin
                    q_push      = 1'b1;
                    q_push_data = cell_idx(cur_x, cur_y);
                    next_state  = POP;
                end
            end
            POP: begin
                if (q_empty) begin
                    next_state = FIN;
                end else begin
                    q_pop      = 1'b1;
                    next_state = NB_RD;
                end
            end
            NB_RD: begin
                if (nb_skip) begin
                    if (nb_last) begin
                        next_state = POP;
                    end
                end else begin
                    rd_en      = 1'b1;
                    rd_x       = {1'b0, nx[2:0]};
                    rd_y       = {1'b0, ny[2:0]};
                    next_state = NB_CHK;
                end
            end
            NB_CHK: begin
                q_push     = color_match;
                next_state = nb_last ? POP : NB_RD;
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Results are only cleared by an accepted start, so they hold after FIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_x     <= '0;
            cur_y     <= '0;
            k         <= '0;
            ref_color <= '0;
            mark      <= '0;
            count     <= '0;
            ok        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_x <= x[2:0];
                        cur_y <= y[2:0];
                        mark  <= '0;
                        count <= '0;
                        ok    <= 1'b0;
                    end
                end
                SEED_CHK: begin
                    if (!seed_empty) begin
                        ref_color                   <= rd_color;
                        mark[cell_idx(cur_x, cur_y)] <= 1'b1;
                        count                       <= 7'd1;
                    end
                end
                POP: begin
                    if (q_empty) begin
                        ok <= (count >= 7'(MIN_GROUP));
                    end else begin
                        cur_x <= q_pop_data[2:0];
                        cur_y <= q_pop_data[5:3];
                        k     <= '0;
                    end
                end
                NB_RD: begin
                    if (nb_skip && !nb_last) begin
                        k <= k + 1'b1;
                    end
                end
                NB_CHK: begin
                    if (color_match) begin
                        mark[nb_idx] <= 1'b1;
                        count        <= count + 7'd1;
                    end
                    if (!nb_last) begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flood_mark.sv
// Directed, table-driven bench for flood_mark with a behavioural board RAM.
// Expected values follow the build: FLOOD_DIAG_EN changes neighbourhood results.
module tb_flood_mark;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        rd_en;
    logic [3:0]  rd_x;
    logic [3:0]  rd_y;
    logic [2:0]  rd_color;
    logic        busy;
    logic        done;
    logic        ok;
    logic [6:0]  count;
    logic [63:0] mark;

    logic [2:0]  board [64];
    int          n_checks;
    int          n_fail;

    typedef struct {
        string       name;
        logic [2:0]  fill;
        logic [2:0]  ovl_color;
        logic [63:0] ovl_mask;
        logic [3:0]  sx;
        logic [3:0]  sy;
        logic [6:0]  exp_count;
        logic [63:0] exp_mark;
        logic        exp_ok;
        int          exp_cycles;
        int          exp_reads;
    } vec_t;

    vec_t vecs [9];

    flood_mark #(.COLOR_W(3), .MIN_GROUP(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x        (x),
        .y        (y),
        .rd_en    (rd_en),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_color (rd_color),
        .busy     (busy),
        .done     (done),
        .ok       (ok),
        .count    (count),
        .mark     (mark)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_color <= board[{rd_y[2:0], rd_x[2:0]}];
        end
    end

    task automatic check_output(input string what, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", what, actual, expected);
        end
    endtask

    // Cycles are counted from the edge that samples start (1) to the edge raising done.
    task automatic apply_stimulus(input vec_t v, input int disturb_at);
        int cyc;
        int reads;
        int bad_reads;
        int busy_gaps;
        int extra_done;
        bit seen_done;
        for (int i = 0; i < 64; i++) begin
            board[i] = v.ovl_mask[i] ? v.ovl_color : v.fill;
        end
        @(negedge clk);
        start = 1'b1;
        x     = v.sx;
        y     = v.sy;
        @(posedge clk);
        cyc = 0; reads = 0; bad_reads = 0; busy_gaps = 0; extra_done = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == disturb_at) begin
                start = 1'b1;
                x     = 4'd0;
                y     = 4'd0;
            end
            if (rd_en) begin
                reads++;
                if (rd_x > 4'd7 || rd_y > 4'd7) bad_reads++;
            end
            if (!busy) busy_gaps++;
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        check_output({v.name, " done_seen"}, 64'(seen_done), 64'd1);
        if (v.exp_cycles > 0) check_output({v.name, " done_cycle"}, 64'(cyc), 64'(v.exp_cycles));
        if (v.exp_reads >= 0) check_output({v.name, " reads"}, 64'(reads), 64'(v.exp_reads));
        check_output({v.name, " offboard_reads"}, 64'(bad_reads), 64'd0);
        check_output({v.name, " busy_gaps"}, 64'(busy_gaps), 64'd0);
        check_output({v.name, " count"}, 64'(count), 64'(v.exp_count));
        check_output({v.name, " mark"}, mark, v.exp_mark);
        check_output({v.name, " ok"}, 64'(ok), 64'(v.exp_ok));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check_output({v.name, " idle_after_done"}, 64'(extra_done), 64'd0);
        check_output({v.name, " count_held"}, 64'(count), 64'(v.exp_count));
        check_output({v.name, " mark_held"}, mark, v.exp_mark);
        check_output({v.name, " ok_held"}, 64'(ok), 64'(v.exp_ok));
    endtask

    initial begin
        int   done_pulses;
        vec_t full_v;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        x        = 4'd0;
        y        = 4'd0;
        for (int i = 0; i < 64; i++) board[i] = 3'd0;

`ifdef FLOOD_DIAG_EN
        vecs[1] = '{"corner", 3'd3, 3'd2, 64'h1, 4'd0, 4'd0, 7'd1, 64'h1, 1'b0, 16, 4};
        vecs[3] = '{"lshape", 3'd1, 3'd4, 64'h0000_0020_101C_0000, 4'd2, 4'd2, 7'd5,
                    64'h0000_0020_101C_0000, 1'b1, 0, -1};
        vecs[4] = '{"isolated", 3'd3, 3'd1, 64'h0000_0008_0000_0000, 4'd3, 4'd4, 7'd1,
                    64'h0000_0008_0000_0000, 1'b0, 21, 9};
        vecs[5] = '{"msb_diff", 3'd5, 3'd1, 64'h200, 4'd1, 4'd1, 7'd1, 64'h200, 1'b0, 21, 9};
`else
        vecs[1] = '{"corner", 3'd3, 3'd2, 64'h1, 4'd0, 4'd0, 7'd1, 64'h1, 1'b0, 11, 3};
        vecs[3] = '{"lshape", 3'd1, 3'd4, 64'h0000_0020_101C_0000, 4'd2, 4'd2, 7'd4,
                    64'h0000_0000_101C_0000, 1'b1, 0, -1};
        vecs[4] = '{"isolated", 3'd3, 3'd1, 64'h0000_0008_0000_0000, 4'd3, 4'd4, 7'd1,
                    64'h0000_0008_0000_0000, 1'b0, 13, 5};
        vecs[5] = '{"msb_diff", 3'd5, 3'd1, 64'h200, 4'd1, 4'd1, 7'd1, 64'h200, 1'b0, 13, 5};
`endif
        vecs[0] = '{"full", 3'd1, 3'd0, 64'h0, 4'd3, 4'd3, 7'd64, {64{1'b1}}, 1'b1, 0, -1};
        vecs[2] = '{"empty_seed", 3'd0, 3'd0, 64'h0, 4'd5, 4'd5, 7'd0, 64'h0, 1'b0, 3, 1};
        vecs[6] = '{"pair", 3'd1, 3'd7, 64'hC000_0000_0000_0000, 4'd7, 4'd7, 7'd2,
                    64'hC000_0000_0000_0000, 1'b1, 0, -1};
        vecs[7] = '{"bad_x", 3'd1, 3'd0, 64'h0, 4'd9, 4'd0, 7'd0, 64'h0, 1'b0, 1, 0};
        vecs[8] = '{"bad_y", 3'd2, 3'd0, 64'h0, 4'd2, 4'd8, 7'd0, 64'h0, 1'b0, 1, 0};

        repeat (3) @(negedge clk);
        check_output("reset busy_done_ok_rd", {60'd0, busy, done, ok, rd_en}, 64'd0);
        check_output("reset count", 64'(count), 64'd0);
        check_output("reset mark", mark, 64'd0);
        check_output("reset rd_xy", {56'd0, rd_x, rd_y}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i], 0);
        end

        // A start pulse mid-fill must not restart or disturb the running fill.
        apply_stimulus(vecs[3], 4);
        apply_stimulus(vecs[3], 9);

        // Reset mid-fill: outputs return to zero and no done pulse appears.
        full_v = vecs[0];
        for (int i = 0; i < 64; i++) board[i] = full_v.fill;
        @(negedge clk);
        start = 1'b1;
        x     = 4'd3;
        y     = 4'd3;
        @(negedge clk);
        start       = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_pulses++;
        end
        check_output("midreset busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midreset busy_done_ok_rd", {60'd0, busy, done, ok, rd_en}, 64'd0);
        check_output("midreset count", 64'(count), 64'd0);
        check_output("midreset mark", mark, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done || busy) done_pulses++;
        end
        check_output("midreset no_done", 64'(done_pulses), 64'd0);

        apply_stimulus(vecs[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
